// File: rtl/calc_display_scan.sv
// calc_display_scan: captures the core's digit stream into a shadow buffer,
// commits complete 8-digit frames atomically and scans them onto eight
// common-anode 7-segment displays. While the core reports an error, the
// displays show "Erro" instead of the committed frame.
// Optional feature: define CALC_DISP_ZERO_BLANK_EN to blank leading zeros
// on displays 7..1 (display 0 always shows its digit).
module calc_display_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);

  // Segment patterns {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_O     = 7'b0100011;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [3:0]    r_shadow [8];
  logic [3:0]    r_disp   [8];
  logic          r_err;
  logic          r_prev_end;
  logic [CW-1:0] r_div_cnt;
  logic [2:0]    r_idx;

  // pos[3] set means pos >= 8, i.e. end of frame
  logic w_pos_end;
  logic w_commit;
  logic w_capture;
  logic w_err_set;

  assign w_pos_end = pos[3];
  assign w_commit  = w_pos_end & ~r_prev_end;
  assign w_capture = (status == 2'b01) & ~w_pos_end;
  assign w_err_set = (status == 2'b00);

  // Capture incoming digits into the shadow buffer while the core is busy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) r_shadow[k] <= '0;
    end else if (w_capture) begin
      r_shadow[pos[2:0]] <= data;
    end
  end

  // Commit on the rising edge into end-of-frame; error set overrides the clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 8; k++) r_disp[k] <= '0;
      r_err      <= 1'b0;
      r_prev_end <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_prev_end <= w_pos_end;
      frame_done <= w_commit;
      if (w_commit) begin
        for (int k = 0; k < 8; k++) r_disp[k] <= r_shadow[k];
      end
      if (w_err_set) r_err <= 1'b1;
      else if (w_commit) r_err <= 1'b0;
    end
  end

  // Refresh divider and digit index rotation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
      r_idx     <= r_idx + 3'd1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // w_blank_vec[i]: display i would be a leading zero (never true for display 0)
  logic [7:0] w_blank_vec;
  logic [3:0] w_digit;
  logic       w_blank;
  logic [6:0] w_digit_seg;
  logic [6:0] w_err_seg;
  logic [6:0] w_seg_next;

`ifdef CALC_DISP_ZERO_BLANK_EN
  assign w_blank_vec[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_lz
      if (gi == 7) begin : g_top
        assign w_blank_vec[gi] = (r_disp[gi] == 4'd0);
      end else begin : g_mid
        assign w_blank_vec[gi] = (r_disp[gi] == 4'd0) & w_blank_vec[gi+1];
      end
    end
  endgenerate
`else
  assign w_blank_vec = 8'h00;
`endif

  assign w_digit = r_disp[r_idx];
  assign w_blank = w_blank_vec[r_idx];

  // BCD to 7-segment decode; codes 10..15 render blank
  always_comb begin
    w_digit_seg = SEG_BLANK;
    case (w_digit)
      4'd0: w_digit_seg = 7'b1000000;
      4'd1: w_digit_seg = 7'b1111001;
      4'd2: w_digit_seg = 7'b0100100;
      4'd3: w_digit_seg = 7'b0110000;
      4'd4: w_digit_seg = 7'b0011001;
      4'd5: w_digit_seg = 7'b0010010;
      4'd6: w_digit_seg = 7'b0000010;
      4'd7: w_digit_seg = 7'b1111000;
      4'd8: w_digit_seg = 7'b0000000;
      4'd9: w_digit_seg = 7'b0010000;
      default: w_digit_seg = SEG_BLANK;
    endcase
  end

  // "Erro" on displays 3..0, blank on 7..4
  always_comb begin
    w_err_seg = SEG_BLANK;
    case (r_idx)
      3'd3: w_err_seg = SEG_E;
      3'd2: w_err_seg = SEG_R;
      3'd1: w_err_seg = SEG_R;
      3'd0: w_err_seg = SEG_O;
      default: w_err_seg = SEG_BLANK;
    endcase
  end

  assign w_seg_next = r_err   ? w_err_seg :
                      w_blank ? SEG_BLANK : w_digit_seg;

  // Registered display drive; dark during reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(8'd1 << r_idx);
      seg <= w_seg_next;
    end
  end

endmodule
